// File: rtl/fb_line_fetch_sched.sv
// Per-line framebuffer prefetch scheduler. Issues burst reads so each active
// line lands in one half of a ping-pong line buffer before the line starts.
module fb_line_fetch_sched #(
  parameter int unsigned H_ACTIVE     = 1280,
  parameter int unsigned V_ACTIVE     = 720,
  parameter int unsigned PIX_PER_WORD = 4,
  parameter int unsigned WORD_BYTES   = 16,
  parameter int unsigned BURST_LEN    = 32,
  parameter int unsigned LINE_STRIDE  = 5120
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] fb_base,
  input  logic        vsync,
  input  logic        de,
  input  logic [11:0] y,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic [7:0]  req_len,
  input  logic        rd_beat,
  output logic        wr_buf,
  output logic [11:0] fetch_line,
  output logic [1:0]  buf_ready,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] underrun_cnt,
  output logic        frame_err
);

  localparam int unsigned WordsPerLine  = H_ACTIVE / PIX_PER_WORD;
  localparam int unsigned BurstsPerLine = WordsPerLine / BURST_LEN;
  localparam logic [31:0] BurstBytes    = 32'(BURST_LEN * WORD_BYTES);
  localparam logic [31:0] Stride        = 32'(LINE_STRIDE);
  localparam logic [8:0]  LastBeat      = 9'(WordsPerLine - 1);
  localparam logic [3:0]  LastBurst     = 4'(BurstsPerLine - 1);
  localparam logic [7:0]  BurstLenM1    = 8'(BURST_LEN - 1);
  localparam logic [12:0] VLimit        = 13'(V_ACTIVE);

  typedef enum logic [1:0] {StIdle, StWaitTrig, StIssue, StWaitData} state_e;

  state_e      state_q;
  logic        vsync_q, de_q;
  logic [11:0] y_q;
  logic [31:0] line_addr_q;
  logic [11:0] next_line_q;
  logic [1:0]  pending_q, pending_n;
  logic        fs_pend_q;
  logic [3:0]  burst_q;
  logic [8:0]  beat_q;
  logic [1:0]  buf_ready_n;

  logic fs, ls, le, le_queues, le_overflow, line_done, fetching, fs_in_fetch, apply;

  assign fs          = vsync_q & ~vsync;
  assign ls          = de & ~de_q;
  assign le          = de_q & ~de;
  // Only lines that still have a successor two lines down get a fetch queued.
  assign le_queues   = le && (({1'b0, y_q} + 13'd2) < VLimit);
  assign fetching    = (state_q == StIssue) || (state_q == StWaitData);
  assign line_done   = (state_q == StWaitData) && rd_beat && (beat_q == LastBeat);
  assign fs_in_fetch = fs && fetching;
  // A frame start is applied right away when not fetching, else at line completion.
  assign apply       = enable && ((fs && (state_q == StIdle || state_q == StWaitTrig)) ||
                                  (line_done && (fs_pend_q || fs)));

  // Pending-line count: LE adds, completion removes; both together cancel out.
  always_comb begin
    pending_n   = pending_q;
    le_overflow = 1'b0;
    if (le_queues && !line_done) begin
      if (pending_q == 2'd2) le_overflow = 1'b1;
      else                   pending_n   = pending_q + 2'd1;
    end else if (!le_queues && line_done && pending_q != 2'd0) begin
      pending_n = pending_q - 2'd1;
    end
  end

  // Buffer ready flags: a same-cycle clear from LE overrides the completion set.
  always_comb begin
    buf_ready_n = buf_ready;
    if (line_done) buf_ready_n[fetch_line[0]] = 1'b1;
    if (le)        buf_ready_n[y_q[0]]        = 1'b0;
  end

  // Timing-generator edge detection and line-number capture.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      y_q     <= 12'd0;
    end else begin
      vsync_q <= vsync;
      de_q    <= de;
      if (de) y_q <= y;
    end
  end

  // Fetch FSM with all bookkeeping and registered outputs.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      req_valid    <= 1'b0;
      req_addr     <= 32'd0;
      req_len      <= BurstLenM1;
      wr_buf       <= 1'b0;
      fetch_line   <= 12'd0;
      buf_ready    <= 2'b00;
      busy         <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 16'd0;
      frame_err    <= 1'b0;
      line_addr_q  <= 32'd0;
      next_line_q  <= 12'd0;
      pending_q    <= 2'd0;
      fs_pend_q    <= 1'b0;
      burst_q      <= 4'd0;
      beat_q       <= 9'd0;
    end else begin
      req_len   <= BurstLenM1;
      underrun  <= ls && !buf_ready[y[0]];
      frame_err <= le_overflow || fs_in_fetch;
      if (ls && !buf_ready[y[0]] && underrun_cnt != 16'hFFFF) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
      if (fetching && rd_beat) beat_q <= beat_q + 9'd1;

      if (apply) begin
        line_addr_q <= fb_base;
        next_line_q <= 12'd0;
        pending_q   <= 2'd2;
        buf_ready   <= 2'b00;
        fs_pend_q   <= 1'b0;
      end else begin
        pending_q <= pending_n;
        buf_ready <= buf_ready_n;
        if (line_done) begin
          next_line_q <= next_line_q + 12'd1;
          line_addr_q <= line_addr_q + Stride;
          fs_pend_q   <= 1'b0;
        end else if (fs_in_fetch) begin
          fs_pend_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (apply) state_q <= StWaitTrig;
        end
        StWaitTrig: begin
          if (fs) begin
            if (!enable) state_q <= StIdle;
          end else if (pending_q != 2'd0) begin
            fetch_line <= next_line_q;
            wr_buf     <= next_line_q[0];
            burst_q    <= 4'd0;
            beat_q     <= 9'd0;
            req_valid  <= 1'b1;
            req_addr   <= line_addr_q;
            busy       <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (req_valid && req_ready) begin
            req_valid <= 1'b0;
            if (burst_q == LastBurst) state_q <= StWaitData;
            else                      burst_q <= burst_q + 4'd1;
          end else if (!req_valid) begin
            req_valid <= 1'b1;
            req_addr  <= req_addr + BurstBytes;
          end
        end
        StWaitData: begin
          if (line_done) begin
            busy    <= 1'b0;
            state_q <= enable ? StWaitTrig : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_line_fetch_sched.sv
// Directed testbench for fb_line_fetch_sched with a simple in-order memory model.
module tb_fb_line_fetch_sched;

  logic        pix_clk, rst, enable, vsync, de;
  logic        req_valid, req_ready, rd_beat, wr_buf, busy, underrun, frame_err;
  logic [31:0] fb_base, req_addr;
  logic [11:0] y, fetch_line;
  logic [7:0]  req_len;
  logic [1:0]  buf_ready;
  logic [15:0] underrun_cnt;

  int checks   = 0;
  int failures = 0;

  // Memory model state
  int          outstanding = 0;
  int          stall_left  = 0;
  int          stall_seen  = 0;
  int          stall_bad   = 0;
  int          stall_cycles = 7;
  logic        stall_armed = 1'b0;
  logic [31:0] stall_addr  = 32'h0;
  logic        beats_on    = 1'b1;
  logic        ready_en    = 1'b1;
  logic [31:0] hs_addr[$];
  logic [7:0]  hs_len[$];

  localparam logic [74:0] RstVec = {1'b0, 32'h0, 8'd31, 1'b0, 12'h0, 2'b00, 1'b0, 1'b0,
                                    16'h0, 1'b0};

  fb_line_fetch_sched dut (
    .pix_clk      (pix_clk),
    .rst          (rst),
    .enable       (enable),
    .fb_base      (fb_base),
    .vsync        (vsync),
    .de           (de),
    .y            (y),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .rd_beat      (rd_beat),
    .wr_buf       (wr_buf),
    .fetch_line   (fetch_line),
    .buf_ready    (buf_ready),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .frame_err    (frame_err)
  );

  initial begin
    pix_clk = 1'b0;
    forever #5 pix_clk = ~pix_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Memory side: acts on the falling edge, inputs stable for the next rising edge.
  initial begin
    req_ready = 1'b0;
    rd_beat   = 1'b0;
    forever begin
      @(negedge pix_clk);
      if (rst) begin
        outstanding = 0;
        stall_left  = 0;
        req_ready   = 1'b0;
        rd_beat     = 1'b0;
      end else begin
        if (beats_on && outstanding > 0) begin
          rd_beat     = 1'b1;
          outstanding = outstanding - 1;
        end else begin
          rd_beat = 1'b0;
        end
        if (stall_armed && req_valid && req_addr == stall_addr) begin
          stall_armed = 1'b0;
          stall_left  = stall_cycles;
        end
        if (stall_left > 0) begin
          req_ready  = 1'b0;
          stall_seen = stall_seen + 1;
          if (!req_valid || req_addr != stall_addr) stall_bad = stall_bad + 1;
          stall_left = stall_left - 1;
        end else begin
          req_ready = ready_en;
        end
        if (req_valid && req_ready) begin
          hs_addr.push_back(req_addr);
          hs_len.push_back(req_len);
          outstanding = outstanding + 32;
        end
      end
    end
  end

  function automatic logic [74:0] outs();
    return {req_valid, req_addr, req_len, wr_buf, fetch_line, buf_ready, busy, underrun,
            underrun_cnt, frame_err};
  endfunction

  task automatic step();
    @(negedge pix_clk);
    #1;
  endtask

  // Leaves vsync low in the detection cycle; the next rising edge sees the fall.
  task automatic fire_fs();
    step();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
  endtask

  task automatic wait_buf(input logic [1:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (buf_ready === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_hs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (hs_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if (outs() !== RstVec) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", outs(), RstVec);
    end
    rst      = 1'b0;
    ready_en = 1'b0;
    fire_fs();
    step();
    step();
    checks++;
    if (req_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_precond_valid: got %b expected 1", req_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== RstVec) begin
      failures++;
      $display("FAIL reset_async: got %h expected %h", outs(), RstVec);
    end
    step();
    checks++;
    if (outs() !== RstVec) begin
      failures++;
      $display("FAIL reset_next_edge: got %h expected %h", outs(), RstVec);
    end
    rst      = 1'b0;
    vsync    = 1'b1;
    ready_en = 1'b1;
    repeat (20) step();
    checks++;
    if ({busy, req_valid, hs_addr.size() == 0} !== 3'b001) begin
      failures++;
      $display("FAIL reset_stays_idle: got busy=%b valid=%b hs=%0d expected 0 0 0",
               busy, req_valid, hs_addr.size());
    end
  endtask

  task automatic test_frame_start();
    bit ok;
    hs_addr.delete();
    hs_len.delete();
    fb_base = 32'h1000_0000;
    fire_fs();
    step();
    checks++;
    if (req_valid !== 1'b0) begin
      failures++;
      $display("FAIL fs_e1_valid: got %b expected 0", req_valid);
    end
    step();
    checks++;
    if ({req_valid, busy, req_addr} !== {1'b1, 1'b1, 32'h1000_0000}) begin
      failures++;
      $display("FAIL fs_e2_request: got v=%b b=%b a=%h expected 1 1 10000000",
               req_valid, busy, req_addr);
    end
    wait_buf(2'b01, ok);
    checks++;
    if (ok !== 1'b1 || hs_addr.size() != 10) begin
      failures++;
      $display("FAIL fs_line0_done: got ok=%b hs=%0d expected 1 10", ok, hs_addr.size());
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({hs_addr[k], hs_len[k]} !== {32'h1000_0000 + 32'(k * 512), 8'd31}) begin
        failures++;
        $display("FAIL fs_line0_req%0d: got %h/%0d expected %h/31", k, hs_addr[k], hs_len[k],
                 32'h1000_0000 + 32'(k * 512));
      end
    end
    wait_buf(2'b11, ok);
    checks++;
    if (ok !== 1'b1 || hs_addr.size() != 20) begin
      failures++;
      $display("FAIL fs_line1_done: got ok=%b hs=%0d expected 1 20", ok, hs_addr.size());
    end
    for (int k = 10; k < 20; k++) begin
      checks++;
      if (hs_addr[k] !== 32'h1000_1400 + 32'((k - 10) * 512)) begin
        failures++;
        $display("FAIL fs_line1_req%0d: got %h expected %h", k - 10, hs_addr[k],
                 32'h1000_1400 + 32'((k - 10) * 512));
      end
    end
    checks++;
    if ({fetch_line, wr_buf} !== {12'd1, 1'b1}) begin
      failures++;
      $display("FAIL fs_line1_id: got line=%0d wr_buf=%b expected 1 1", fetch_line, wr_buf);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    hs_addr.delete();
    hs_len.delete();
    stall_seen  = 0;
    stall_bad   = 0;
    stall_addr  = 32'h1000_0600;
    stall_armed = 1'b1;
    fire_fs();
    wait_buf(2'b01, ok);
    checks++;
    if (ok !== 1'b1 || hs_addr.size() != 10) begin
      failures++;
      $display("FAIL bp_line0_hs: got ok=%b hs=%0d expected 1 10", ok, hs_addr.size());
    end
    checks++;
    if (stall_seen != 7 || stall_bad != 0) begin
      failures++;
      $display("FAIL bp_stable: got stalled=%0d unstable=%0d expected 7 0",
               stall_seen, stall_bad);
    end
    checks++;
    if (hs_addr[3] !== 32'h1000_0600) begin
      failures++;
      $display("FAIL bp_burst3_addr: got %h expected 10000600", hs_addr[3]);
    end
    wait_buf(2'b11, ok);
    checks++;
    if (ok !== 1'b1 || hs_addr.size() != 20) begin
      failures++;
      $display("FAIL bp_line1_hs: got ok=%b hs=%0d expected 1 20", ok, hs_addr.size());
    end
  endtask

  task automatic test_line_end();
    bit ok;
    hs_addr.delete();
    step();
    de = 1'b1;
    y  = 12'd0;
    repeat (3) step();
    de = 1'b0;
    step();
    checks++;
    if (buf_ready !== 2'b10) begin
      failures++;
      $display("FAIL le_clear: got %b expected 10", buf_ready);
    end
    wait_hs(1, ok);
    checks++;
    if (ok !== 1'b1 || hs_addr[0] !== 32'h1000_2800) begin
      failures++;
      $display("FAIL le_line2_addr: got ok=%b addr=%h expected 1 10002800", ok, hs_addr[0]);
    end
    wait_buf(2'b11, ok);
    checks++;
    if (ok !== 1'b1 || fetch_line !== 12'd2 || hs_addr.size() != 10) begin
      failures++;
      $display("FAIL le_line2_done: got ok=%b line=%0d hs=%0d expected 1 2 10",
               ok, fetch_line, hs_addr.size());
    end
    hs_addr.delete();
    step();
    de = 1'b1;
    y  = 12'd718;
    repeat (3) step();
    de = 1'b0;
    repeat (30) step();
    checks++;
    if (hs_addr.size() != 0 || busy !== 1'b0 || buf_ready !== 2'b10) begin
      failures++;
      $display("FAIL le_last_no_fetch: got hs=%0d busy=%b buf=%b expected 0 0 10",
               hs_addr.size(), busy, buf_ready);
    end
    checks++;
    if (underrun_cnt !== 16'd0) begin
      failures++;
      $display("FAIL le_no_underrun: got %0d expected 0", underrun_cnt);
    end
  endtask

  task automatic test_underrun();
    beats_on = 1'b0;
    hs_addr.delete();
    fire_fs();
    repeat (4) step();
    de = 1'b1;
    y  = 12'd0;
    step();
    checks++;
    if ({underrun, underrun_cnt} !== {1'b1, 16'd1}) begin
      failures++;
      $display("FAIL underrun_pulse: got %b/%0d expected 1/1", underrun, underrun_cnt);
    end
    step();
    checks++;
    if ({underrun, underrun_cnt} !== {1'b0, 16'd1}) begin
      failures++;
      $display("FAIL underrun_one_cycle: got %b/%0d expected 0/1", underrun, underrun_cnt);
    end
  endtask

  task automatic test_mid_fetch_fs();
    bit ok;
    wait_hs(10, ok);
    repeat (3) step();
    checks++;
    if (ok !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_in_wait_data: got ok=%b busy=%b expected 1 1", ok, busy);
    end
    fb_base = 32'h2000_0000;
    fire_fs();
    step();
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL mid_frame_err: got %b expected 1", frame_err);
    end
    step();
    checks++;
    if (frame_err !== 1'b0 || hs_addr.size() != 10) begin
      failures++;
      $display("FAIL mid_frame_err_once: got err=%b hs=%0d expected 0 10",
               frame_err, hs_addr.size());
    end
    beats_on = 1'b1;
    wait_hs(11, ok);
    checks++;
    if (ok !== 1'b1 || hs_addr[10] !== 32'h2000_0000 || fetch_line !== 12'd0) begin
      failures++;
      $display("FAIL mid_new_frame: got ok=%b addr=%h line=%0d expected 1 20000000 0",
               ok, hs_addr[10], fetch_line);
    end
    checks++;
    if (buf_ready !== 2'b00) begin
      failures++;
      $display("FAIL mid_buf_cleared: got %b expected 00", buf_ready);
    end
    wait_buf(2'b01, ok);
    checks++;
    if (ok !== 1'b1 || hs_addr.size() != 20) begin
      failures++;
      $display("FAIL mid_line0_done: got ok=%b hs=%0d expected 1 20", ok, hs_addr.size());
    end
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    fb_base = 32'h1000_0000;
    vsync   = 1'b1;
    de      = 1'b0;
    y       = 12'd0;
    test_reset();
    test_frame_start();
    test_backpressure();
    test_line_end();
    test_underrun();
    test_mid_fetch_fs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_line_fetch_sched.md
# fb_line_fetch_sched

Per-line framebuffer prefetch scheduler for the 1280x720 display path. It watches the timing generator's `de`, `y` and `vsync` outputs and issues burst read requests to the memory port, so that each active line sits in one half of a two-line ping-pong pixel buffer before that line starts. It is the only requester on the display read port. It tracks data-beat arrival, publishes per-buffer ready flags and reports underruns.

## Interface
Parameters:
- `H_ACTIVE`, default 1280: active pixels per line.
- `V_ACTIVE`, default 720: active lines per frame.
- `PIX_PER_WORD`, default 4: pixels per memory data beat. Words per line = `H_ACTIVE/PIX_PER_WORD` = 320.
- `WORD_BYTES`, default 16: bytes per data beat.
- `BURST_LEN`, default 32: beats per request. Bursts per line = 320/32 = 10. Must divide words per line.
- `LINE_STRIDE`, default 5120: byte distance between line starts.

Ports:
- `pix_clk`, in, 1: sole clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: scheduler enable. Sampled only at frame start and at line completion.
- `fb_base`, in, 32: frame byte base address. Latched at each applied frame start.
- `vsync`, in, 1: active-low vsync from the timing generator.
- `de`, in, 1: data enable from the timing generator.
- `y`, in, 12: current line from the timing generator. Valid while `de` = 1.
- `req_valid`, out, 1: read request valid.
- `req_ready`, in, 1: memory accepts the request.
- `req_addr`, out, 32: request byte address.
- `req_len`, out, 8: beats minus one (`BURST_LEN-1`).
- `rd_beat`, in, 1: one read data beat returned. Beats arrive in order.
- `wr_buf`, out, 1: buffer half the returning beats belong to (`fetch_line[0]`).
- `fetch_line`, out, 12: line currently being fetched.
- `buf_ready`, out, 2: bit b = buffer b holds a complete line.
- `busy`, out, 1: FSM is in ISSUE or WAIT_DATA.
- `underrun`, out, 1: one-cycle pulse.
- `underrun_cnt`, out, 16: count of underruns, saturating.
- `frame_err`, out, 1: one-cycle pulse.

## Operation
Edge detection uses registered copies of `vsync` and `de`:
- Frame start (FS): `vsync` falls.
- Line start (LS): `de` rises.
- Line end (LE): `de` falls. `y` is captured on the last `de`=1 cycle.

State machine, states IDLE, WAIT_TRIG, ISSUE, WAIT_DATA:
- **Applying a frame start** (`enable`=1): latch `fb_base` into `line_addr`; `next_line`=0; `pending`=2; `buf_ready`=00.
- **IDLE**: on FS with `enable`=1, apply the frame start and go to WAIT_TRIG. Otherwise remain in IDLE.
- **WAIT_TRIG**: if `pending`>0, load `fetch_line`=`next_line`, set burst index k=0, clear the beat counter, and go to ISSUE.
- **ISSUE**: `req_addr` = `line_addr` + k·`BURST_LEN`·`WORD_BYTES`. On `req_valid`&&`req_ready`, k++. After the 10th handshake, go to WAIT_DATA.
- **WAIT_DATA**: count `rd_beat`. Beats are also counted during ISSUE. When the count reaches 320:
  - set `buf_ready[fetch_line[0]]`;
  - `pending`--; `next_line`++; `line_addr` += `LINE_STRIDE`;
  - go to WAIT_TRIG. If a frame start is pending, apply it instead; with `enable`=0, go to IDLE.
- **LE for line y**: clear `buf_ready[y[0]]`. If y+2 < `V_ACTIVE`, `pending`++. If `pending` is already 2, the increment is dropped and `frame_err` pulses.
- **LS for line y** with `buf_ready[y[0]]`=0: `underrun` pulses and `underrun_cnt` increments, saturating at 0xFFFF.
- **FS in WAIT_TRIG**: apply the frame start immediately.
- **FS in ISSUE or WAIT_DATA**: `frame_err` pulses and the frame start is held pending. The current line completes, and the frame start is applied at completion. Queued fetches are discarded.
- **Simultaneous LE and completion** in one cycle: `pending` changes by net 0.
- **Same-cycle set and clear of one `buf_ready` bit**: the clear wins.

Arithmetic:
- Addresses are 32-bit and wrap modulo 2^32.
- Beat counter is 9-bit. Beats arriving in WAIT_TRIG or IDLE are ignored.

## Timing
- Reset values: `req_valid`=0, `req_addr`=0, `req_len`=`BURST_LEN-1`, `wr_buf`=0, `fetch_line`=0, `buf_ready`=00, `busy`=0, `underrun`=0, `underrun_cnt`=0, `frame_err`=0, FSM in IDLE. Reset mid-burst is immediate; the memory side is reset with the same `rst`.
- All outputs are registered.
- FS or LE detected in cycle E; WAIT_TRIG is entered at E+1; `req_valid` is high from E+2.
- `req_valid`/`req_addr`/`req_len` hold stable until accepted.
- The next request is presented in the cycle after acceptance, giving one request per two cycles at most.
- `buf_ready` sets in the cycle after the 320th beat.
- `underrun` and `frame_err` are high for exactly one cycle.

## Test plan
- **Reset**: assert `rst` mid-ISSUE with `req_valid`=1. Required: all outputs at reset values next edge, and FSM idle until the next FS.
- **Frame start**: FS with `fb_base`=0x1000_0000, `req_ready`=1, beats returned promptly. Required:
  - 10 requests at 0x1000_0000 + 512k, each with `req_len`=31;
  - then `buf_ready`=01;
  - then line 1 requests from 0x1000_1400;
  - then `buf_ready`=11.
- **Backpressure**: hold `req_ready`=0 for 7 cycles on burst 3. Required: `req_addr`=0x1000_0600 stable throughout, and exactly 10 handshakes per line.
- **Line end**: LE with y=0. Required: `buf_ready[0]` clears, and line 2 fetch starts at base+10240. LE with y=718: no fetch is queued.
- **Underrun**: LS with y=0 before any beat is returned. Required: one `underrun` pulse and `underrun_cnt`=1.
- **Mid-fetch frame start**: FS while in WAIT_DATA. Required: `frame_err` pulse, current line completes, then `fetch_line`=0 at the newly latched `fb_base`.
